// File: rtl/image_line_packer.sv
// image_line_packer: zero-extends lane pixels to output words, tags line start/end on ch0,
// counts completed and aborted lines; gated by synced power-enable, re-armed by frame-enable edge.
module image_line_packer #(
  parameter int          LVDS_PAIRS  = 8,
  parameter int          PIX_BITS    = 12,
  parameter int          OUT_BITS    = 16,
  parameter int          LINE_LEN    = 256,
  parameter logic [3:0]  SOL_TAG     = 4'hF,
  parameter bit          EOL_TAG_EN  = 1'b0,
  parameter logic [3:0]  EOL_TAG     = 4'hE,
  parameter int          GAP_TIMEOUT = 1024
) (
  input  logic                           clk_rxg,
  input  logic                           rst_rx_n,
  input  logic                           eds_power_en,
  input  logic                           eds_frame_en,
  input  logic                           lval_in,
  input  logic [LVDS_PAIRS*PIX_BITS-1:0] data_in,
  input  logic                           err_clr,
  output logic                           lval_out,
  output logic [LVDS_PAIRS*OUT_BITS-1:0] data_out,
  output logic                           sol_out,
  output logic                           eol_out,
  output logic                           frame_start,
  output logic [15:0]                    line_cnt,
  output logic                           short_line_err,
  output logic [7:0]                     short_line_cnt
);
  localparam int TAG_BITS = OUT_BITS - PIX_BITS;
  localparam int CW = $clog2(LINE_LEN) + 1;
  localparam int GW = $clog2(GAP_TIMEOUT + 1) + 1;
  localparam int DW = LVDS_PAIRS * OUT_BITS;

  typedef enum logic [1:0] {OFF, ARMED, LINE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        pwr_sync_q, fe_sync_q;
  logic [CW-1:0]     beat_q, beat_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              lval_q, lval_d, sol_q, sol_d, eol_q, eol_d, fs_q, fs_d, serr_q, serr_d;
  logic [DW-1:0]     data_q, data_d, pack;
  logic [15:0]       line_cnt_q, line_cnt_d;
  logic [7:0]        scnt_q, scnt_d, scnt_base;
  logic              pwr, fedge, emit, first, last, abort;
  logic [TAG_BITS-1:0] tag0;

  assign pwr   = pwr_sync_q[1];
  assign fedge = fe_sync_q[0] & ~fe_sync_q[1];
  assign tag0  = first ? TAG_BITS'(SOL_TAG) : (last && EOL_TAG_EN) ? TAG_BITS'(EOL_TAG) : '0;

  always_comb begin
    pack = '0;
    for (int i = 0; i < LVDS_PAIRS; i++)
      pack[i*OUT_BITS +: PIX_BITS] = data_in[i*PIX_BITS +: PIX_BITS];
    pack[PIX_BITS +: TAG_BITS] = tag0;
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    line_cnt_d = line_cnt_q;
    data_d     = data_q;
    fs_d       = fedge;
    abort      = 1'b0;
    emit       = 1'b0;
    first      = state_q == ARMED;
    last       = beat_q == CW'(LINE_LEN - 1);
    if (!pwr) begin
      abort      = state_q == LINE;
      state_d    = OFF;
      beat_d     = '0;
      gap_d      = '0;
      data_d     = '0;
      line_cnt_d = '0;
    end else if (fedge) begin
      abort      = state_q == LINE;
      state_d    = ARMED;
      beat_d     = '0;
      gap_d      = '0;
      line_cnt_d = '0;
    end else if (state_q == OFF) begin
      state_d = ARMED;
    end else if (lval_in) begin
      emit    = 1'b1;
      gap_d   = '0;
      data_d  = pack;
      beat_d  = last ? '0 : beat_q + CW'(1);
      state_d = last ? ARMED : LINE;
      if (last) line_cnt_d = (line_cnt_q == 16'hFFFF) ? line_cnt_q : line_cnt_q + 16'd1;
    end else if (state_q == LINE) begin
      gap_d = gap_q + GW'(1);
      if (GAP_TIMEOUT != 0 && gap_d == GW'(GAP_TIMEOUT)) begin
        abort   = 1'b1;
        state_d = ARMED;
        beat_d  = '0;
        gap_d   = '0;
      end
    end
    lval_d    = emit;
    sol_d     = emit & first;
    eol_d     = emit & last;
    // a clear in the same cycle as an abort is applied before the abort counts
    scnt_base = err_clr ? 8'd0 : scnt_q;
    scnt_d    = (abort && scnt_base != 8'hFF) ? scnt_base + 8'd1 : scnt_base;
    serr_d    = (serr_q & ~err_clr) | abort;
  end

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      pwr_sync_q <= '0;
      fe_sync_q  <= '0;
      state_q    <= OFF;
      beat_q     <= '0;
      gap_q      <= '0;
      lval_q     <= 1'b0;
      sol_q      <= 1'b0;
      eol_q      <= 1'b0;
      fs_q       <= 1'b0;
      data_q     <= '0;
      line_cnt_q <= '0;
      serr_q     <= 1'b0;
      scnt_q     <= '0;
    end else begin
      pwr_sync_q <= {pwr_sync_q[0], eds_power_en};
      fe_sync_q  <= {fe_sync_q[0], eds_frame_en};
      state_q    <= state_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      lval_q     <= lval_d;
      sol_q      <= sol_d;
      eol_q      <= eol_d;
      fs_q       <= fs_d;
      data_q     <= data_d;
      line_cnt_q <= line_cnt_d;
      serr_q     <= serr_d;
      scnt_q     <= scnt_d;
    end
  end

  assign lval_out       = lval_q;
  assign sol_out        = sol_q;
  assign eol_out        = eol_q;
  assign frame_start    = fs_q;
  assign data_out       = data_q;
  assign line_cnt       = line_cnt_q;
  assign short_line_err = serr_q;
  assign short_line_cnt = scnt_q;
endmodule

// File: tb/tb_image_line_packer.sv
// tb_image_line_packer: scoreboard bench; stimulus queues expected beats, a monitor pops them
// on every lval_out and status outputs are checked at fixed points in the sequence.
module tb_image_line_packer;
  logic         clk = 1'b0;
  logic         rst_n, pwr_en, frame_en, lval_in, err_clr;
  logic [95:0]  data_in;
  logic         lval_out, sol_out, eol_out, frame_start, short_line_err;
  logic [127:0] data_out;
  logic [15:0]  line_cnt;
  logic [7:0]   short_line_cnt;
  int checks = 0, failures = 0;

  typedef struct {logic [127:0] d; logic s; logic e;} exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  image_line_packer #(.LINE_LEN(4), .EOL_TAG_EN(1'b1), .GAP_TIMEOUT(16)) dut (
    .clk_rxg(clk), .rst_rx_n(rst_n), .eds_power_en(pwr_en), .eds_frame_en(frame_en),
    .lval_in(lval_in), .data_in(data_in), .err_clr(err_clr), .lval_out(lval_out),
    .data_out(data_out), .sol_out(sol_out), .eol_out(eol_out), .frame_start(frame_start),
    .line_cnt(line_cnt), .short_line_err(short_line_err), .short_line_cnt(short_line_cnt));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] ramp(input int base);
    logic [95:0] r;
    for (int i = 0; i < 8; i++) r[i*12 +: 12] = 12'(base * 8 + i);
    return r;
  endfunction

  function automatic logic [127:0] ext(input logic [95:0] d, input logic [3:0] t);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = {4'h0, d[i*12 +: 12]};
    r[15:12] = t;
    return r;
  endfunction

  task automatic beat(input int base, input logic [3:0] t, input bit s, input bit e);
    @(negedge clk);
    lval_in = 1'b1;
    data_in = ramp(base);
    exp_q.push_back('{ext(ramp(base), t), s, e});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      lval_in = 1'b0;
    end
  endtask

  task automatic line(input int base);
    beat(base, 4'hF, 1, 0);
    beat(base + 1, 4'h0, 0, 0);
    beat(base + 2, 4'h0, 0, 0);
    beat(base + 3, 4'hE, 0, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && lval_out) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 128'(lval_out), 128'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("beat_data", data_out, e.d);
        chk("beat_sol", 128'(sol_out), 128'(e.s));
        chk("beat_eol", 128'(eol_out), 128'(e.e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; pwr_en = 1'b1; frame_en = 1'b0; lval_in = 1'b0; err_clr = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_lval", 128'(lval_out), 128'd0);
    chk("rst_data", data_out, 128'd0);
    chk("rst_line_cnt", 128'(line_cnt), 128'd0);
    chk("rst_err", 128'(short_line_err), 128'd0);
    chk("rst_scnt", 128'(short_line_cnt), 128'd0);
    chk("rst_fs", 128'(frame_start), 128'd0);
    rst_n = 1'b1;
    idle(4);
    // contiguous line; first beat checked against a hand-built word
    beat(0, 4'hF, 1, 0);
    beat(1, 4'h0, 0, 0);
    chk("first_word", data_out, 128'h0007_0006_0005_0004_0003_0002_0001_F000);
    beat(2, 4'h0, 0, 0);
    beat(3, 4'hE, 0, 1);
    idle(1);
    chk("line_cnt_1", 128'(line_cnt), 128'd1);
    chk("hold_data", data_out, ext(ramp(3), 4'hE));
    // line with 3-cycle gaps
    beat(10, 4'hF, 1, 0); idle(3);
    beat(11, 4'h0, 0, 0); idle(3);
    beat(12, 4'h0, 0, 0); idle(3);
    beat(13, 4'hE, 0, 1); idle(1);
    chk("line_cnt_2", 128'(line_cnt), 128'd2);
    // 15-cycle gap is below the timeout
    beat(20, 4'hF, 1, 0); idle(15);
    beat(21, 4'h0, 0, 0);
    beat(22, 4'h0, 0, 0);
    beat(23, 4'hE, 0, 1); idle(1);
    chk("gap15_err", 128'(short_line_err), 128'd0);
    chk("line_cnt_3", 128'(line_cnt), 128'd3);
    // 16-cycle gap aborts
    beat(30, 4'hF, 1, 0);
    beat(31, 4'h0, 0, 0);
    idle(16);
    @(negedge clk);
    chk("timeout_err", 128'(short_line_err), 128'd1);
    chk("timeout_scnt", 128'(short_line_cnt), 128'd1);
    chk("timeout_line_cnt", 128'(line_cnt), 128'd3);
    line(40); idle(1);
    chk("line_cnt_4", 128'(line_cnt), 128'd4);
    // frame-enable rises mid-line; coincident beat is dropped
    beat(50, 4'hF, 1, 0);
    beat(51, 4'h0, 0, 0);
    @(negedge clk); lval_in = 1'b0; frame_en = 1'b1;
    @(negedge clk); lval_in = 1'b1; data_in = ramp(99);
    @(negedge clk); lval_in = 1'b0;
    chk("fedge_fs", 128'(frame_start), 128'd1);
    chk("fedge_lval", 128'(lval_out), 128'd0);
    chk("fedge_line_cnt", 128'(line_cnt), 128'd0);
    chk("fedge_scnt", 128'(short_line_cnt), 128'd2);
    @(negedge clk);
    chk("fs_pulse_end", 128'(frame_start), 128'd0);
    line(60); idle(1);
    chk("fedge_line_cnt_1", 128'(line_cnt), 128'd1);
    // power drop mid-line
    beat(70, 4'hF, 1, 0);
    beat(71, 4'h0, 0, 0);
    @(negedge clk); lval_in = 1'b0; pwr_en = 1'b0;
    idle(3);
    chk("off_lval", 128'(lval_out), 128'd0);
    chk("off_data", data_out, 128'd0);
    chk("off_line_cnt", 128'(line_cnt), 128'd0);
    chk("off_scnt", 128'(short_line_cnt), 128'd3);
    chk("off_err", 128'(short_line_err), 128'd1);
    pwr_en = 1'b1;
    idle(4);
    line(80); idle(1);
    chk("pwr_line_cnt", 128'(line_cnt), 128'd1);
    // err_clr coincident with a timeout abort
    beat(90, 4'hF, 1, 0);
    idle(15);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_abort_scnt", 128'(short_line_cnt), 128'd1);
    chk("clr_abort_err", 128'(short_line_err), 128'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_scnt", 128'(short_line_cnt), 128'd0);
    chk("clr_err", 128'(short_line_err), 128'd0);
    chk("clr_line_cnt", 128'(line_cnt), 128'd1);
    // saturation of the abort counter
    for (int k = 0; k < 300; k++) begin
      beat(100 + k, 4'hF, 1, 0);
      idle(16);
    end
    @(negedge clk);
    chk("sat_scnt", 128'(short_line_cnt), 128'd255);
    chk("sat_err", 128'(short_line_err), 128'd1);
    // asynchronous reset in the middle of an output beat
    @(negedge clk); lval_in = 1'b1; data_in = ramp(7);
    @(posedge clk); #1;
    chk("pre_rst_lval", 128'(lval_out), 128'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_lval", 128'(lval_out), 128'd0);
    chk("async_data", data_out, 128'd0);
    chk("async_sol", 128'(sol_out), 128'd0);
    chk("async_scnt", 128'(short_line_cnt), 128'd0);
    chk("async_err", 128'(short_line_err), 128'd0);
    chk("async_line_cnt", 128'(line_cnt), 128'd0);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
